// File: rtl/adder_tree_gather.sv
// -----------------------------------------------------------------------------
// adder_tree_gather
//
// Serial-to-parallel gather stage that sits directly in front of adder_tree.
// One signed IDATA_WIDTH sample is accepted per input handshake. INPUTS_NUM
// consecutive samples are packed into the vector that adder_tree consumes.
// The vector is presented through a registered valid/ready output.
//
// Optional feature (macro ADDER_TREE_GATHER_LAST_EN):
//   defined   - ilast closes a frame early. The unused lanes are zero-padded,
//               so the downstream sum is unaffected, and ocount reports the
//               number of populated lanes.
//   undefined - ilast is ignored. Only full vectors are emitted, and ocount
//               is always INPUTS_NUM once a vector has been loaded.
//
// Parameters:
//   INPUTS_NUM  - lanes per output vector (>= 2, any value)
//   IDATA_WIDTH - width of one sample
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   ivalid - input sample valid
//   iready - stage can take a sample this cycle (combinational, independent
//            of ivalid)
//   idata  - input sample (opaque bits; adder_tree does the sign extension)
//   ilast  - sample closes the current frame (qualified by ivalid && iready)
//   ovalid - output vector valid
//   oready - downstream accepts the vector
//   odata  - gathered vector; lane 0 holds the first sample of the frame
//   ocount - number of populated lanes in odata (1..INPUTS_NUM)
// -----------------------------------------------------------------------------
module adder_tree_gather #(
    parameter int INPUTS_NUM  = 8,
    parameter int IDATA_WIDTH = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        ivalid,
    output logic                                        iready,
    input  logic signed [IDATA_WIDTH-1:0]               idata,
    input  logic                                        ilast,
    output logic                                        ovalid,
    input  logic                                        oready,
    output logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0]      odata,
    output logic [$clog2(INPUTS_NUM+1)-1:0]             ocount
);

    localparam int LANE_W = $clog2(INPUTS_NUM);
    localparam int CNT_W  = $clog2(INPUTS_NUM+1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(INPUTS_NUM - 1);

    typedef logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] vec_t;

    // Lane counter and fill buffer. The top lane of fill_p0 is never written,
    // because the sample for lane INPUTS_NUM-1 always closes the frame and
    // goes straight into the output register.
    logic [LANE_W-1:0] cnt;
    vec_t              fill_p0;

    logic cnt_last;
    logic closing;
    logic accept;
    logic load;

    // Assemble the outgoing vector. Lanes below the closing lane come from the
    // fill buffer, the closing lane takes the live sample, and every lane above
    // it is forced to zero. This keeps leftovers from longer earlier frames out
    // of a short frame.
    function automatic vec_t build_vec(
        input vec_t                    fill,
        input logic [LANE_W-1:0]       close_lane,
        input logic [IDATA_WIDTH-1:0]  sample
    );
        vec_t v;
        v = '0;
        for (int k = 0; k < INPUTS_NUM; k++) begin
            if (k < int'(close_lane)) begin
                v[k] = fill[k];
            end else if (k == int'(close_lane)) begin
                v[k] = sample;
            end else begin
                v[k] = '0;
            end
        end
        return v;
    endfunction

    // Number of populated lanes for a frame closing on close_lane.
    function automatic logic [CNT_W-1:0] lane_count(
        input logic [LANE_W-1:0] close_lane
    );
`ifdef ADDER_TREE_GATHER_LAST_EN
        return CNT_W'(close_lane) + CNT_W'(1);
`else
        // Only full frames exist in this build.
        return (close_lane == LAST_LANE) ? CNT_W'(INPUTS_NUM) : CNT_W'(INPUTS_NUM);
`endif
    endfunction

    assign cnt_last = (cnt == LAST_LANE);

`ifdef ADDER_TREE_GATHER_LAST_EN
    assign closing = cnt_last || ilast;
`else
    logic unused_ilast;
    assign unused_ilast = ilast;
    assign closing      = cnt_last;
`endif

    // A non-closing sample only touches the fill buffer, so it can always be
    // taken. A closing sample needs the output register. That register is
    // free when it is empty or when it is being drained in this same cycle.
    assign iready = !closing || !ovalid || oready;
    assign accept = ivalid && iready;
    assign load   = accept && closing;

    // ---- stage p0: fill buffer (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (accept && !closing) begin
            fill_p0[cnt] <= idata;
        end
    end

    // ---- stage p0: lane counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            if (closing) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + LANE_W'(1);
            end
        end
    end

    // ---- stage p1: output register ----
    // A load takes priority over the drain-clear. A transfer and a load in the
    // same cycle therefore keep ovalid high and swap in the new vector without
    // a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovalid <= 1'b0;
            odata  <= '0;
            ocount <= '0;
        end else if (load) begin
            ovalid <= 1'b1;
            odata  <= build_vec(fill_p0, cnt, idata);
            ocount <= lane_count(cnt);
        end else if (ovalid && oready) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_gather.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_gather
//
// Self-checking bench for adder_tree_gather with INPUTS_NUM=8, IDATA_WIDTH=8.
// The reference model is frame-level. It collects accepted samples in a queue
// and turns a closed frame into the expected vector, lane count and signed
// sum. It keeps a one-entry output slot. The model honours ilast only when
// ADDER_TREE_GATHER_LAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_tree_gather;

    localparam int N = 8;
    localparam int W = 8;

`ifdef ADDER_TREE_GATHER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b0;
    logic                    ivalid = 1'b0;
    logic                    ilast  = 1'b0;
    logic                    oready = 1'b0;
    logic [W-1:0]            idata  = '0;
    logic                    iready;
    logic                    ovalid;
    logic [N-1:0][W-1:0]     odata;
    logic [$clog2(N+1)-1:0]  ocount;

    adder_tree_gather #(
        .INPUTS_NUM  (N),
        .IDATA_WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ivalid (ivalid),
        .iready (iready),
        .idata  (idata),
        .ilast  (ilast),
        .ovalid (ovalid),
        .oready (oready),
        .odata  (odata),
        .ocount (ocount)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: open frame plus a one-entry output slot.
    logic [W-1:0]        frame[$];
    bit                  slot_vld;
    int                  slot_len;
    int                  slot_sum;
    logic [N-1:0][W-1:0] slot_vec;

    function automatic bit model_closes(input bit l);
        return (frame.size() == N - 1) || (LAST_EN && l);
    endfunction

    function automatic bit model_iready(input bit l, input bit r);
        return !(model_closes(l) && slot_vld && !r);
    endfunction

    task automatic model_clear();
        frame.delete();
        slot_vld = 1'b0;
        slot_len = 0;
        slot_sum = 0;
        slot_vec = '0;
    endtask

    // One clock cycle. Entered at posedge+1. Inputs are driven here, checked
    // and modelled at the negedge, and the task returns at the next posedge+1.
    task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit r,
                        output bit acc);
        bit exp_rdy;
        int s;
        ivalid = v;
        idata  = d;
        ilast  = l;
        oready = r;
        @(negedge clk);
        exp_rdy = model_iready(l, r);
        check_val("iready", 64'(iready), 64'(exp_rdy));
        check_val("ovalid", 64'(ovalid), 64'(slot_vld));
        if (slot_vld) begin
            check_val("odata", 64'(odata), 64'(slot_vec));
            check_val("ocount", 64'(ocount), 64'(slot_len));
            if (r) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'($signed(odata[k]));
                check_val("tree_sum", 64'(s), 64'(slot_sum));
            end
        end
        if (slot_vld && r) slot_vld = 1'b0;
        acc = v && exp_rdy;
        if (acc) begin
            frame.push_back(d);
            if (frame.size() == N || (LAST_EN && l)) begin
                slot_vec = '0;
                slot_sum = 0;
                foreach (frame[i]) begin
                    slot_vec[i] = frame[i];
                    slot_sum += int'($signed(frame[i]));
                end
                slot_len = frame.size();
                slot_vld = 1'b1;
                frame.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    bit acc;

    initial begin
        model_clear();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ovalid", 64'(ovalid), 64'(0));
        check_val("rst_odata", 64'(odata), 64'(0));
        check_val("rst_ocount", 64'(ocount), 64'(0));
        check_val("rst_iready", 64'(iready), 64'(1));
        rst_n = 1'b1;

        // Full frames back-to-back
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b1, acc);
            check_val("b2b_accept", 64'(acc), 64'(1));
        end
        drain(3);

        // Back-pressure: 15 samples fit, the 16th waits for a drain
        for (int i = 1; i <= 15; i++) step(1'b1, W'(i + 32), 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(48), 1'b0, 1'b0, acc);
            check_val("bp_stall", 64'(acc), 64'(0));
        end
        step(1'b1, W'(48), 1'b0, 1'b1, acc);
        check_val("bp_release", 64'(acc), 64'(1));
        step(1'b0, '0, 1'b0, 1'b0, acc);
        drain(3);

        // Partial frame 5, -3, 7
        step(1'b1, W'(5), 1'b0, 1'b1, acc);
        step(1'b1, 8'hFD, 1'b0, 1'b1, acc);
        step(1'b1, W'(7), 1'b1, 1'b1, acc);
        drain(2);

        // Stale lanes: full frame of 0x7F, then a one-sample frame
        for (int i = 0; i < N; i++) step(1'b1, 8'h7F, 1'b0, 1'b1, acc);
        step(1'b1, 8'h01, 1'b1, 1'b1, acc);
        drain(2);

        // Reset mid-frame
        for (int i = 0; i < 4; i++) step(1'b1, W'(9), 1'b0, 1'b1, acc);
        ivalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ovalid", 64'(ovalid), 64'(0));
        check_val("mid_rst_odata", 64'(odata), 64'(0));
        check_val("mid_rst_ocount", 64'(ocount), 64'(0));
        check_val("mid_rst_iready", 64'(iready), 64'(1));
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain(2);
        for (int i = 0; i < N; i++) step(1'b1, W'(2), 1'b0, 1'b1, acc);
        drain(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0), acc);
        end
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
